// File: rtl/rv32i_mc_core.sv
// Multicycle RV32I core: one FSM sequences FETCH/DECODE/EXECUTE/MEM/WB and halts precisely on traps.
// Zero-wait latency: branch 3, ALU/jump/store 4, load 5 cycles; wait states stall in FETCH/MEM with req held.
module rv32i_mc_core #(
  parameter logic [31:0] RESET_PC      = 32'h00001000,
  parameter bit          WB_FORWARD_EN = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [2:0]  dmem_funct3,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ready,
  input  logic [31:0] dmem_rdata,
  output logic        retire,
  output logic        halted,
  output logic [2:0]  trap_cause
);
  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXECUTE, S_MEM, S_WB, S_HALT
  } state_t;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  state_t      state, state_nxt;
  logic [31:0] pc, pc_next, pc_plus4, ir, rs1_val, rs2_val, imm_q, alu_q, target_q, load_q;
  logic [31:0] regs [32];
  logic [2:0]  cause_q, cause_nxt;
  logic        halted_q, retire_q, retire_now;

  logic [6:0]  opcode;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  f3;
  logic        is_lui, is_auipc, is_jal, is_jalr, is_br, is_ld, is_st, is_opi, is_op, is_sys, known;

  assign opcode   = ir[6:0];
  assign rd       = ir[11:7];
  assign f3       = ir[14:12];
  assign rs1      = ir[19:15];
  assign rs2      = ir[24:20];
  assign is_lui   = opcode == OP_LUI;
  assign is_auipc = opcode == OP_AUIPC;
  assign is_jal   = opcode == OP_JAL;
  assign is_jalr  = opcode == OP_JALR;
  assign is_br    = opcode == OP_BRANCH;
  assign is_ld    = opcode == OP_LOAD;
  assign is_st    = opcode == OP_STORE;
  assign is_opi   = opcode == OP_IMM;
  assign is_op    = opcode == OP_REG;
  assign is_sys   = opcode == OP_SYSTEM;
  assign known    = is_lui | is_auipc | is_jal | is_jalr | is_br | is_ld | is_st
                  | is_opi | is_op | is_sys;

  logic [31:0] imm_dec;
  always_comb begin
    imm_dec = {{20{ir[31]}}, ir[31:20]};
    case (opcode)
      OP_STORE:         imm_dec = {{20{ir[31]}}, ir[31:25], ir[11:7]};
      OP_BRANCH:        imm_dec = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
      OP_LUI, OP_AUIPC: imm_dec = {ir[31:12], 12'h000};
      OP_JAL:           imm_dec = {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};
      default:          ;
    endcase
  end

  // Non-ALU classes (loads, stores, AUIPC) use the adder path, giving rs1+imm or pc+imm.
  logic [31:0] op_a, op_b, alu_y, tgt_sum, target, wb_data;
  logic        taken, misaligned;
  assign op_a = is_auipc ? pc : rs1_val;
  assign op_b = is_op ? rs2_val : imm_q;

  always_comb begin
    alu_y = op_a + op_b;
    if (is_op || is_opi) begin
      case (f3)
        3'b000:  if (is_op && ir[30]) alu_y = op_a - op_b;
        3'b001:  alu_y = op_a << op_b[4:0];
        3'b010:  alu_y = {31'b0, $signed(op_a) < $signed(op_b)};
        3'b011:  alu_y = {31'b0, op_a < op_b};
        3'b100:  alu_y = op_a ^ op_b;
        3'b101:  alu_y = ir[30] ? 32'($signed(op_a) >>> op_b[4:0]) : op_a >> op_b[4:0];
        3'b110:  alu_y = op_a | op_b;
        default: alu_y = op_a & op_b;
      endcase
    end
  end

  always_comb begin
    case (f3)
      3'b000:  taken = rs1_val == rs2_val;
      3'b001:  taken = rs1_val != rs2_val;
      3'b100:  taken = $signed(rs1_val) < $signed(rs2_val);
      3'b101:  taken = $signed(rs1_val) >= $signed(rs2_val);
      3'b110:  taken = rs1_val < rs2_val;
      3'b111:  taken = rs1_val >= rs2_val;
      default: taken = 1'b0;
    endcase
  end

  always_comb begin
    case (f3[1:0])
      2'b01:   misaligned = alu_y[0];
      2'b10:   misaligned = alu_y[1:0] != 2'b00;
      default: misaligned = 1'b0;
    endcase
  end

  assign tgt_sum  = (is_jalr ? rs1_val : pc) + imm_q;
  assign target   = {tgt_sum[31:1], tgt_sum[0] & ~is_jalr};
  assign pc_plus4 = pc + 32'd4;
  assign wb_data  = is_ld ? load_q : is_lui ? imm_q : (is_jal || is_jalr) ? pc_plus4 : alu_q;
  assign pc_next  = (state == S_EXECUTE) ? (taken ? target : pc_plus4)
                  : (state == S_WB && (is_jal || is_jalr)) ? target_q : pc_plus4;

  always_comb begin
    state_nxt  = state;
    cause_nxt  = cause_q;
    retire_now = 1'b0;
    case (state)
      S_FETCH:  if (imem_ready) state_nxt = S_DECODE;
      S_DECODE: begin
        if (known) state_nxt = S_EXECUTE;
        else begin
          state_nxt = S_HALT;
          cause_nxt = 3'd1;
        end
      end
      S_EXECUTE: begin
        if (is_br) begin
          state_nxt  = S_FETCH;
          retire_now = 1'b1;
        end else if (is_ld || is_st) begin
          if (misaligned) begin
            state_nxt = S_HALT;
            cause_nxt = is_ld ? 3'd3 : 3'd4;
          end else state_nxt = S_MEM;
        end else if (is_jal || is_jalr) begin
          if (target[1]) begin
            state_nxt = S_HALT;
            cause_nxt = 3'd2;
          end else state_nxt = S_WB;
        end else if (is_sys) begin
          state_nxt = S_HALT;
          cause_nxt = (imm_q == 32'd0) ? 3'd5 : (imm_q == 32'd1) ? 3'd6 : 3'd1;
        end else state_nxt = S_WB;
      end
      S_MEM: begin
        if (dmem_ready) begin
          state_nxt  = is_st ? S_FETCH : S_WB;
          retire_now = is_st;
        end
      end
      S_WB: begin
        state_nxt  = S_FETCH;
        retire_now = 1'b1;
      end
      S_HALT:  ;
      default: state_nxt = S_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_FETCH;
      pc       <= RESET_PC;
      halted_q <= 1'b0;
      cause_q  <= 3'd0;
      retire_q <= 1'b0;
    end else begin
      state    <= state_nxt;
      cause_q  <= cause_nxt;
      retire_q <= retire_now;
      if (state_nxt == S_HALT) halted_q <= 1'b1;
      if (retire_now) pc <= pc_next;
    end
  end

  // Datapath registers need no reset; gating on reset makes a same-cycle ready a no-op.
  always_ff @(posedge clk) begin
    if (!reset) begin
      case (state)
        S_FETCH:   if (imem_ready) ir <= imem_rdata;
        S_DECODE: begin
          rs1_val <= (rs1 == 5'd0) ? 32'd0 : regs[rs1];
          rs2_val <= (rs2 == 5'd0) ? 32'd0 : regs[rs2];
          imm_q   <= imm_dec;
        end
        S_EXECUTE: begin
          alu_q    <= alu_y;
          target_q <= target;
        end
        S_MEM:     if (dmem_ready) load_q <= dmem_rdata;
        default:   ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && state == S_WB && rd != 5'd0) regs[rd] <= wb_data;
  end

  assign imem_req    = !reset && state == S_FETCH;
  assign imem_addr   = pc;
  assign dmem_req    = !reset && state == S_MEM;
  assign dmem_we     = dmem_req && is_st;
  assign dmem_funct3 = f3;
  assign dmem_addr   = alu_q;
  assign dmem_wdata  = rs2_val;
  assign retire      = !reset && (WB_FORWARD_EN ? retire_now : retire_q);
  assign halted      = halted_q;
  assign trap_cause  = cause_q;
endmodule

// File: tb/tb_rv32i_mc_core.sv
// Directed bench for rv32i_mc_core: a cycle-exact script plays both memories and checks every handshake.
module tb_rv32i_mc_core;
    logic        clk;
    logic        reset, imem_req, imem_ready, dmem_req, dmem_we, dmem_ready, retire, halted;
    logic [31:0] imem_addr, imem_rdata, dmem_addr, dmem_wdata, dmem_rdata;
    logic [2:0]  dmem_funct3, trap_cause;

    logic        reset_b, imem_req_b, imem_ready_b, dmem_req_b, dmem_we_b, dmem_ready_b;
    logic        retire_b, halted_b;
    logic [31:0] imem_addr_b, imem_rdata_b, dmem_addr_b, dmem_wdata_b, dmem_rdata_b;
    logic [2:0]  dmem_funct3_b, trap_cause_b;

    int vecs = 0;
    int errs = 0;

    rv32i_mc_core dut (
        .clk(clk), .reset(reset),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready), .imem_rdata(imem_rdata),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_funct3(dmem_funct3), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_ready(dmem_ready), .dmem_rdata(dmem_rdata),
        .retire(retire), .halted(halted), .trap_cause(trap_cause)
    );

    rv32i_mc_core #(.RESET_PC(32'h00000200), .WB_FORWARD_EN(1'b0)) dut_b (
        .clk(clk), .reset(reset_b),
        .imem_req(imem_req_b), .imem_addr(imem_addr_b), .imem_ready(imem_ready_b),
        .imem_rdata(imem_rdata_b),
        .dmem_req(dmem_req_b), .dmem_we(dmem_we_b), .dmem_funct3(dmem_funct3_b),
        .dmem_addr(dmem_addr_b), .dmem_wdata(dmem_wdata_b), .dmem_ready(dmem_ready_b),
        .dmem_rdata(dmem_rdata_b),
        .retire(retire_b), .halted(halted_b), .trap_cause(trap_cause_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        if (obs !== exp) begin
            errs++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] i_enc(int imm, int rs1, int f3, int rd, int op);
        return {imm[11:0], rs1[4:0], f3[2:0], rd[4:0], op[6:0]};
    endfunction
    function automatic logic [31:0] r_enc(int f7, int rs2, int rs1, int f3, int rd);
        return {f7[6:0], rs2[4:0], rs1[4:0], f3[2:0], rd[4:0], 7'b0110011};
    endfunction
    function automatic logic [31:0] s_enc(int imm, int rs2, int rs1, int f3);
        return {imm[11:5], rs2[4:0], rs1[4:0], f3[2:0], imm[4:0], 7'b0100011};
    endfunction
    function automatic logic [31:0] b_enc(int imm, int rs2, int rs1, int f3);
        return {imm[12], imm[10:5], rs2[4:0], rs1[4:0], f3[2:0], imm[4:1], imm[11], 7'b1100011};
    endfunction
    function automatic logic [31:0] j_enc(int imm, int rd);
        return {imm[20], imm[10:1], imm[11], imm[19:12], rd[4:0], 7'b1101111};
    endfunction

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; imem_ready = 1'b0; dmem_ready = 1'b0;
        #1;
        chk("rst_imem_req", imem_req, 1'b0);
        chk("rst_dmem_req", dmem_req, 1'b0);
        chk("rst_dmem_we", dmem_we, 1'b0);
        chk("rst_retire", retire, 1'b0);
        tick();
        reset = 1'b0;
        #1;
        chk("rst_halted", halted, 1'b0);
        chk("rst_cause", trap_cause, 3'd0);
    endtask

    // Ends in DECODE, one cycle after the ready cycle.
    task automatic fetch(input logic [31:0] a, input logic [31:0] instr, input int w);
        chk("fetch_req", imem_req, 1'b1);
        chk("fetch_addr", imem_addr, a);
        for (int i = 0; i < w; i++) begin
            tick();
            chk("fetch_wait_req", imem_req, 1'b1);
            chk("fetch_wait_addr", imem_addr, a);
        end
        imem_ready = 1'b1; imem_rdata = instr;
        tick();
        imem_ready = 1'b0; imem_rdata = 32'd0;
        chk("decode_retire", retire, 1'b0);
    endtask

    task automatic run_alu(input logic [31:0] a, input logic [31:0] instr, input int w);
        fetch(a, instr, w);
        tick();
        chk("exec_retire", retire, 1'b0);
        tick();
        chk("wb_retire", retire, 1'b1);
        tick();
    endtask

    task automatic run_branch(input logic [31:0] a, input logic [31:0] instr);
        fetch(a, instr, 0);
        tick();
        chk("br_retire", retire, 1'b1);
        tick();
    endtask

    task automatic run_store(input logic [31:0] a, input logic [31:0] instr, input int w,
                             input logic [31:0] daddr, input logic [31:0] wdata, input int dw);
        fetch(a, instr, w);
        tick();
        chk("st_exec_dreq", dmem_req, 1'b0);
        tick();
        for (int i = 0; i <= dw; i++) begin
            chk("st_dreq", dmem_req, 1'b1);
            chk("st_we", dmem_we, 1'b1);
            chk("st_f3", dmem_funct3, 3'b010);
            chk("st_addr", dmem_addr, daddr);
            chk("st_wdata", dmem_wdata, wdata);
            if (i < dw) begin
                chk("st_wait_retire", retire, 1'b0);
                tick();
            end
        end
        dmem_ready = 1'b1;
        #1;
        chk("st_retire", retire, 1'b1);
        tick();
        dmem_ready = 1'b0;
    endtask

    task automatic run_load(input logic [31:0] a, input logic [31:0] instr, input int w,
                            input logic [31:0] daddr, input logic [31:0] rdata, input int dw);
        fetch(a, instr, w);
        tick();
        tick();
        for (int i = 0; i <= dw; i++) begin
            chk("ld_dreq", dmem_req, 1'b1);
            chk("ld_we", dmem_we, 1'b0);
            chk("ld_addr", dmem_addr, daddr);
            if (i < dw) tick();
        end
        dmem_ready = 1'b1; dmem_rdata = rdata;
        tick();
        dmem_ready = 1'b0; dmem_rdata = 32'd0;
        chk("ld_wb_retire", retire, 1'b1);
        tick();
    endtask

    task automatic run_fault(input logic [31:0] a, input logic [31:0] instr, input bit at_decode,
                             input logic [2:0] cause);
        fetch(a, instr, 0);
        chk("flt_pre_halted", halted, 1'b0);
        if (!at_decode) begin
            tick();
            chk("flt_exec_dreq", dmem_req, 1'b0);
            chk("flt_exec_halted", halted, 1'b0);
        end
        tick();
        chk("flt_halted", halted, 1'b1);
        chk("flt_cause", trap_cause, cause);
        for (int i = 0; i < 3; i++) begin
            chk("halt_imem_req", imem_req, 1'b0);
            chk("halt_dmem_req", dmem_req, 1'b0);
            chk("halt_retire", retire, 1'b0);
            tick();
        end
    endtask

    initial begin
        imem_ready = 1'b0; imem_rdata = 32'd0; dmem_ready = 1'b0; dmem_rdata = 32'd0;
        reset_b = 1'b1; imem_ready_b = 1'b0; imem_rdata_b = 32'd0;
        dmem_ready_b = 1'b0; dmem_rdata_b = 32'd0;

        do_reset();
        run_alu(32'h1000, i_enc(5, 0, 0, 1, 7'h13), 0);
        run_alu(32'h1004, i_enc(-3, 1, 0, 2, 7'h13), 0);
        run_alu(32'h1008, r_enc(0, 2, 1, 0, 3), 0);
        run_store(32'h100C, s_enc(8, 3, 0, 2), 2, 32'd8, 32'd7, 3);
        run_load(32'h1010, i_enc(8, 0, 2, 4, 7'h03), 2, 32'd8, 32'd7, 3);
        run_store(32'h1014, s_enc(12, 4, 0, 2), 0, 32'd12, 32'd7, 0);
        run_alu(32'h1018, i_enc(9, 0, 0, 0, 7'h13), 0);
        run_alu(32'h101C, r_enc(0, 0, 0, 0, 6), 0);
        run_store(32'h1020, s_enc(16, 6, 0, 2), 0, 32'd16, 32'd0, 0);
        run_branch(32'h1024, b_enc(8, 0, 0, 0));
        run_branch(32'h102C, b_enc(8, 0, 0, 1));
        run_alu(32'h1030, j_enc(16, 5), 0);
        run_store(32'h1040, s_enc(20, 5, 0, 2), 0, 32'd20, 32'h1034, 0);
        run_fault(32'h1044, i_enc(-50, 5, 0, 5, 7'h67), 1'b0, 3'd2);

        do_reset();
        run_store(32'h1000, s_enc(24, 5, 0, 2), 0, 32'd24, 32'h1034, 0);
        run_fault(32'h1004, i_enc(12'h102, 0, 2, 7, 7'h03), 1'b0, 3'd3);
        do_reset();
        run_fault(32'h1000, s_enc(2, 0, 0, 2), 1'b0, 3'd4);
        do_reset();
        run_fault(32'h1000, 32'h00000000, 1'b1, 3'd1);
        do_reset();
        run_fault(32'h1000, 32'h00000073, 1'b0, 3'd5);
        do_reset();
        run_fault(32'h1000, 32'h00100073, 1'b0, 3'd6);

        do_reset();
        run_alu(32'h1000, i_enc(1, 0, 0, 1, 7'h13), 0);
        run_alu(32'h1004, i_enc(2, 0, 0, 2, 7'h13), 0);
        vecs++;
        if (imem_req !== 1'b1) begin
            errs++;
            $error("FAIL mid_req: observed %0h, expected 1", imem_req);
        end
        vecs++;
        if (imem_addr !== 32'h1008) begin
            errs++;
            $error("FAIL mid_addr: observed %0h, expected 1008", imem_addr);
        end
        tick();
        reset = 1'b1; imem_ready = 1'b1; imem_rdata = i_enc(3, 0, 0, 3, 7'h13);
        #1;
        chk("mid_rst_req", imem_req, 1'b0);
        chk("mid_rst_retire", retire, 1'b0);
        tick();
        reset = 1'b0; imem_ready = 1'b0; imem_rdata = 32'd0;
        #1;
        run_alu(32'h1000, i_enc(1, 0, 0, 1, 7'h13), 0);

        chk("b_rst_req", imem_req_b, 1'b0);
        chk("b_rst_dreq", dmem_req_b, 1'b0);
        tick();
        reset_b = 1'b0;
        #1;
        vecs++;
        if (imem_req_b !== 1'b1) begin
            errs++;
            $error("FAIL b_first_req: observed %0h, expected 1", imem_req_b);
        end
        vecs++;
        if (imem_addr_b !== 32'h200) begin
            errs++;
            $error("FAIL b_first_addr: observed %0h, expected 200", imem_addr_b);
        end
        imem_ready_b = 1'b1; imem_rdata_b = i_enc(1, 0, 0, 1, 7'h13);
        tick();
        imem_ready_b = 1'b0;
        chk("b_dec_retire", retire_b, 1'b0);
        tick();
        chk("b_exec_retire", retire_b, 1'b0);
        tick();
        chk("b_wb_retire", retire_b, 1'b0);
        tick();
        chk("b_late_retire", retire_b, 1'b1);
        chk("b_next_addr", imem_addr_b, 32'h204);
        tick();
        chk("b_retire_drop", retire_b, 1'b0);
        chk("b_wait_req", imem_req_b, 1'b1);
        reset_b = 1'b1;
        #1;
        chk("b_mid_rst_req", imem_req_b, 1'b0);
        tick();
        reset_b = 1'b0;
        #1;
        chk("b_refetch_req", imem_req_b, 1'b1);
        vecs++;
        if (imem_addr_b !== 32'h200) begin
            errs++;
            $error("FAIL b_refetch_addr: observed %0h, expected 200", imem_addr_b);
        end
        chk("b_halted", halted_b, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
